// File: rtl/mmu_mem_arbiter_pkg.sv
// Shared MMU memory-arbiter definitions: FSM encodings, grant identifiers and timeout default.
// Used by the sv32 MMU read path and the arbiter that sits between it and memory.
package mmu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_INST = 2'b01,
    S_DATA = 2'b11
  } state_t;

  typedef enum logic {
    G_INST = 1'b0,
    G_DATA = 1'b1
  } grant_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mmu_mem_arbiter_rr.sv
// Two-requester round-robin pick: on a tie, favour the port that was not served last.
// Purely combinational; the caller decides whether the pick is actually taken.
module mmu_mem_arbiter_rr
  import mmu_mem_arbiter_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  input  grant_t last_grant,
  output logic   gnt_vld,
  output grant_t gnt
);

  always_comb begin
    gnt_vld = inst_req | data_req;
    gnt     = G_INST;
    if (inst_req && data_req) begin
      gnt = (last_grant == G_INST) ? G_DATA : G_INST;
    end else if (data_req) begin
      gnt = G_DATA;
    end
  end

endmodule

// File: rtl/mmu_mem_arbiter.sv
// Shares one memory read channel between MMU instruction and data/PTE reads, one read in flight;
// responses are tag-matched on address, writes pass straight through.
module mmu_mem_arbiter
  import mmu_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        BUS_RDEN,
  output logic [31:0] BUS_RADDR,
  input  logic [31:0] BUS_ROADDR,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA,
  output logic        BUS_WREN,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WADDR,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_WAIT,
  output logic        ARB_WAIT,
  output logic        ARB_TIMEOUT
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [31:0]   req_addr, req_addr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  grant_t        last_grant, last_grant_nxt;

  logic   gnt_vld;
  grant_t gnt;

  mmu_mem_arbiter_rr u_rr (
    .inst_req   (INST_RDEN),
    .data_req   (DATA_RDEN),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  logic        granted;
  logic        serving_data;
  logic        port_rden;
  logic [31:0] port_addr;
  logic        complete;
  logic        abort;
  logic        expired;

  assign granted      = (state == S_INST) || (state == S_DATA);
  assign serving_data = (state == S_DATA);
  assign port_rden    = serving_data ? DATA_RDEN   : INST_RDEN;
  assign port_addr    = serving_data ? DATA_RIADDR : INST_RIADDR;
  // A response only counts if it carries the address we asked for; anything else is stale.
  assign complete     = granted && BUS_RVALID && (BUS_ROADDR == req_addr);
  assign abort        = granted && (!port_rden || (port_addr != req_addr));
  assign expired      = granted && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      cnt        <= '0;
      last_grant <= G_DATA;
    end else begin
      state      <= state_nxt;
      req_addr   <= req_addr_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    req_addr_nxt   = req_addr;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    case (state)
      S_INST, S_DATA: begin
        cnt_nxt = cnt + CW'(1);
        if (complete) begin
          state_nxt      = S_IDLE;
          last_grant_nxt = serving_data ? G_DATA : G_INST;
        end else if (abort || expired) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        if (!BUS_WAIT && gnt_vld) begin
          state_nxt    = (gnt == G_DATA) ? S_DATA : S_INST;
          req_addr_nxt = (gnt == G_DATA) ? DATA_RIADDR : INST_RIADDR;
          cnt_nxt      = '0;
        end
      end
    endcase
  end

  // Outputs are held quiet while RST is high so a reset mid-read never leaks a response.
  always_comb begin
    BUS_RDEN    = 1'b0;
    BUS_RADDR   = '0;
    INST_RVALID = 1'b0;
    INST_ROADDR = '0;
    INST_RDATA  = '0;
    DATA_RVALID = 1'b0;
    DATA_ROADDR = '0;
    DATA_RDATA  = '0;
    ARB_TIMEOUT = 1'b0;
    if (!RST && granted) begin
      BUS_RDEN    = 1'b1;
      BUS_RADDR   = req_addr;
      ARB_TIMEOUT = expired && !complete;
      if (complete) begin
        if (serving_data) begin
          DATA_RVALID = 1'b1;
          DATA_ROADDR = BUS_ROADDR;
          DATA_RDATA  = BUS_RDATA;
        end else begin
          INST_RVALID = 1'b1;
          INST_ROADDR = BUS_ROADDR;
          INST_RDATA  = BUS_RDATA;
        end
      end
    end
  end

  assign BUS_WREN  = DATA_WREN;
  assign BUS_WSTRB = DATA_WSTRB;
  assign BUS_WADDR = DATA_WADDR;
  assign BUS_WDATA = DATA_WDATA;
  assign ARB_WAIT  = BUS_WAIT;

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed bench for mmu_mem_arbiter (TIMEOUT=8): inputs driven 1ns after the rising edge,
// outputs checked 1ns later.
module tb_mmu_mem_arbiter;

  logic        CLK, RST;
  logic        INST_RDEN, DATA_RDEN, DATA_WREN, BUS_RVALID, BUS_WAIT;
  logic [31:0] INST_RIADDR, DATA_RIADDR, DATA_WADDR, DATA_WDATA, BUS_ROADDR, BUS_RDATA;
  logic [3:0]  DATA_WSTRB;
  logic [31:0] INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA, BUS_RADDR, BUS_WADDR, BUS_WDATA;
  logic        INST_RVALID, DATA_RVALID, BUS_RDEN, BUS_WREN, ARB_WAIT, ARB_TIMEOUT;
  logic [3:0]  BUS_WSTRB;

  int errors = 0;
  int checks = 0;

  mmu_mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
    .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
    .DATA_ROADDR(DATA_ROADDR), .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WSTRB(DATA_WSTRB), .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
    .BUS_RDEN(BUS_RDEN), .BUS_RADDR(BUS_RADDR),
    .BUS_ROADDR(BUS_ROADDR), .BUS_RVALID(BUS_RVALID), .BUS_RDATA(BUS_RDATA),
    .BUS_WREN(BUS_WREN), .BUS_WSTRB(BUS_WSTRB), .BUS_WADDR(BUS_WADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_WAIT(BUS_WAIT), .ARB_WAIT(ARB_WAIT), .ARB_TIMEOUT(ARB_TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; INST_RDEN = 0; DATA_RDEN = 0; DATA_WREN = 0; BUS_RVALID = 0; BUS_WAIT = 0;
    INST_RIADDR = 0; DATA_RIADDR = 0; DATA_WADDR = 0; DATA_WDATA = 0; DATA_WSTRB = 0;
    BUS_ROADDR = 0; BUS_RDATA = 0;
    tick();
    tick();
    #1;
    checks++;
    if (BUS_RDEN !== 1'b0 || BUS_RADDR !== 32'h0 || ARB_TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: rden=%b raddr=%h tmo=%b, want 0/0/0", BUS_RDEN, BUS_RADDR, ARB_TIMEOUT);
    end
    checks++;
    if (INST_RVALID !== 1'b0 || DATA_RVALID !== 1'b0 || INST_ROADDR !== 32'h0 || DATA_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_ports: irv=%b drv=%b iro=%h drd=%h, want all 0",
               INST_RVALID, DATA_RVALID, INST_ROADDR, DATA_RDATA);
    end
    RST = 1'b0;
    BUS_WAIT = 1'b1;
    #1;
    checks++;
    if (ARB_WAIT !== 1'b1) begin
      errors++;
      $display("FAIL arb_wait: got %b want 1", ARB_WAIT);
    end
    BUS_WAIT = 1'b0;
    tick();
  endtask

  task automatic test_inst_read();
    INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_1000;
    #1;
    checks++;
    if (BUS_RDEN !== 1'b0) begin
      errors++;
      $display("FAIL inst_idle_rden: got %b want 0", BUS_RDEN);
    end
    tick();
    #1;
    checks++;
    if (BUS_RDEN !== 1'b1 || BUS_RADDR !== 32'h0000_1000 || INST_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL inst_grant: rden=%b raddr=%h irv=%b, want 1/00001000/0", BUS_RDEN, BUS_RADDR, INST_RVALID);
    end
    tick();
    tick();
    BUS_RVALID = 1'b1; BUS_ROADDR = 32'h0000_1000; BUS_RDATA = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (INST_RVALID !== 1'b1 || INST_RDATA !== 32'hDEAD_BEEF || INST_ROADDR !== 32'h0000_1000 || DATA_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL inst_resp: irv=%b ird=%h iro=%h drv=%b, want 1/deadbeef/00001000/0",
               INST_RVALID, INST_RDATA, INST_ROADDR, DATA_RVALID);
    end
    tick();
    BUS_RVALID = 1'b0; INST_RDEN = 1'b0;
    #1;
    checks++;
    if (INST_RVALID !== 1'b0 || BUS_RDEN !== 1'b0) begin
      errors++;
      $display("FAIL inst_after: irv=%b rden=%b, want 0/0", INST_RVALID, BUS_RDEN);
    end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_addr;
    do_reset();
    INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_0100;
    DATA_RDEN = 1'b1; DATA_RIADDR = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      tick();
      checks++;
      if (BUS_RDEN !== 1'b1 || BUS_RADDR !== exp_addr) begin
        errors++;
        $display("FAIL alt_grant%0d: rden=%b raddr=%h, want 1/%h", i, BUS_RDEN, BUS_RADDR, exp_addr);
      end
      BUS_RVALID = 1'b1; BUS_ROADDR = exp_addr; BUS_RDATA = 32'hA000_0000 + i;
      #1;
      checks++;
      if (INST_RVALID !== (i % 2 == 0) || DATA_RVALID !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL alt_resp%0d: irv=%b drv=%b, want %b/%b", i, INST_RVALID, DATA_RVALID,
                 (i % 2 == 0), (i % 2 == 1));
      end
      tick();
      BUS_RVALID = 1'b0;
      #1;
      checks++;
      if (BUS_RDEN !== 1'b0) begin
        errors++;
        $display("FAIL alt_idle%0d: rden=%b want 0", i, BUS_RDEN);
      end
    end
  endtask

  task automatic test_mismatch();
    INST_RDEN = 1'b0; DATA_RIADDR = 32'h0000_2000;
    BUS_RVALID = 1'b1; BUS_ROADDR = 32'h0000_2000; BUS_RDATA = 32'h9999_9999;
    #1;
    checks++;
    if (DATA_RVALID !== 1'b0 || INST_RVALID !== 1'b0 || DATA_ROADDR !== 32'h0) begin
      errors++;
      $display("FAIL idle_resp_drop: drv=%b irv=%b dro=%h, want 0/0/0", DATA_RVALID, INST_RVALID, DATA_ROADDR);
    end
    tick();
    BUS_ROADDR = 32'h0000_3000; BUS_RDATA = 32'h1111_1111;
    #1;
    checks++;
    if (DATA_RVALID !== 1'b0 || BUS_RDEN !== 1'b1 || BUS_RADDR !== 32'h0000_2000) begin
      errors++;
      $display("FAIL mismatch_drop: drv=%b rden=%b raddr=%h, want 0/1/00002000", DATA_RVALID, BUS_RDEN, BUS_RADDR);
    end
    tick();
    BUS_ROADDR = 32'h0000_2000; BUS_RDATA = 32'hCAFE_F00D;
    #1;
    checks++;
    if (DATA_RVALID !== 1'b1 || DATA_RDATA !== 32'hCAFE_F00D || DATA_ROADDR !== 32'h0000_2000) begin
      errors++;
      $display("FAIL mismatch_match: drv=%b drd=%h dro=%h, want 1/cafef00d/00002000",
               DATA_RVALID, DATA_RDATA, DATA_ROADDR);
    end
    tick();
    BUS_RVALID = 1'b0; DATA_RDEN = 1'b0;
    #1;
    checks++;
    if (DATA_RVALID !== 1'b0 || BUS_RDEN !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_after: drv=%b rden=%b, want 0/0", DATA_RVALID, BUS_RDEN);
    end
  endtask

  task automatic test_timeout();
    INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_4000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (ARB_TIMEOUT !== (k == 8) || INST_RVALID !== 1'b0 || BUS_RDEN !== 1'b1) begin
        errors++;
        $display("FAIL timeout_cyc%0d: tmo=%b irv=%b rden=%b, want %b/0/1", k, ARB_TIMEOUT, INST_RVALID,
                 BUS_RDEN, (k == 8));
      end
    end
    tick();
    INST_RDEN = 1'b0;
    #1;
    checks++;
    if (BUS_RDEN !== 1'b0 || ARB_TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: rden=%b tmo=%b, want 0/0", BUS_RDEN, ARB_TIMEOUT);
    end
  endtask

  task automatic test_abort();
    INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_1000;
    tick();
    checks++;
    if (BUS_RADDR !== 32'h0000_1000) begin
      errors++;
      $display("FAIL abort_grant: raddr=%h want 00001000", BUS_RADDR);
    end
    tick();
    INST_RIADDR = 32'h0000_1004;
    #1;
    checks++;
    if (INST_RVALID !== 1'b0 || BUS_RADDR !== 32'h0000_1000) begin
      errors++;
      $display("FAIL abort_change: irv=%b raddr=%h, want 0/00001000", INST_RVALID, BUS_RADDR);
    end
    tick();
    BUS_RVALID = 1'b1; BUS_ROADDR = 32'h0000_1000; BUS_RDATA = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (BUS_RDEN !== 1'b0 || INST_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: rden=%b irv=%b, want 0/0", BUS_RDEN, INST_RVALID);
    end
    tick();
    checks++;
    if (BUS_RDEN !== 1'b1 || BUS_RADDR !== 32'h0000_1004 || INST_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_regrant: rden=%b raddr=%h irv=%b, want 1/00001004/0", BUS_RDEN, BUS_RADDR, INST_RVALID);
    end
    tick();
    BUS_ROADDR = 32'h0000_1004; BUS_RDATA = 32'h55AA_55AA;
    #1;
    checks++;
    if (INST_RVALID !== 1'b1 || INST_RDATA !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL abort_resp: irv=%b ird=%h, want 1/55aa55aa", INST_RVALID, INST_RDATA);
    end
    tick();
    BUS_RVALID = 1'b0; INST_RDEN = 1'b0;
  endtask

  task automatic test_bus_wait();
    BUS_WAIT = 1'b1; DATA_RDEN = 1'b1; DATA_RIADDR = 32'h0000_6000;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (BUS_RDEN !== 1'b0 || ARB_WAIT !== 1'b1) begin
        errors++;
        $display("FAIL wait_hold%0d: rden=%b aw=%b, want 0/1", k, BUS_RDEN, ARB_WAIT);
      end
    end
    BUS_WAIT = 1'b0;
    tick();
    checks++;
    if (BUS_RDEN !== 1'b1 || BUS_RADDR !== 32'h0000_6000) begin
      errors++;
      $display("FAIL wait_release: rden=%b raddr=%h, want 1/00006000", BUS_RDEN, BUS_RADDR);
    end
    DATA_RDEN = 1'b0;
    tick();
    #1;
    checks++;
    if (BUS_RDEN !== 1'b0 || DATA_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL wait_abort: rden=%b drv=%b, want 0/0", BUS_RDEN, DATA_RVALID);
    end
  endtask

  task automatic test_reset_mid();
    DATA_RDEN = 1'b1; DATA_RIADDR = 32'h0000_2000;
    tick();
    DATA_WREN = 1'b1; DATA_WSTRB = 4'b0101; DATA_WADDR = 32'h0000_8000; DATA_WDATA = 32'h1234_5678;
    #1;
    checks++;
    if (BUS_RDEN !== 1'b1 || BUS_WREN !== 1'b1 || BUS_WSTRB !== 4'b0101 ||
        BUS_WADDR !== 32'h0000_8000 || BUS_WDATA !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_pass: rden=%b wren=%b wstrb=%b waddr=%h wdata=%h, want 1/1/0101/00008000/12345678",
               BUS_RDEN, BUS_WREN, BUS_WSTRB, BUS_WADDR, BUS_WDATA);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (BUS_RDEN !== 1'b0 || DATA_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: rden=%b drv=%b, want 0/0", BUS_RDEN, DATA_RVALID);
    end
    tick();
    RST = 1'b0; DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
    BUS_RVALID = 1'b1; BUS_ROADDR = 32'h0000_2000; BUS_RDATA = 32'h7777_7777;
    #1;
    checks++;
    if (BUS_RDEN !== 1'b0 || DATA_RVALID !== 1'b0 || BUS_WREN !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_resp: rden=%b drv=%b wren=%b, want 0/0/0", BUS_RDEN, DATA_RVALID, BUS_WREN);
    end
    BUS_RVALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000ns");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_inst_read();
    test_alternate();
    test_mismatch();
    test_timeout();
    test_abort();
    test_bus_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
